// File: rtl/conv_job_scheduler_pkg.sv
// Shared definitions for the convolution job scheduler: one-hot FSM encodings
// and the job descriptor layout.
package conv_job_scheduler_pkg;

    localparam int DESC_AW = 12;

    localparam int S_IDLE      = 0;
    localparam int S_LAUNCH    = 1;
    localparam int S_WAIT_BUSY = 2;
    localparam int S_RUN       = 3;
    localparam int S_DONE      = 4;
    localparam int S_DRAIN     = 5;
    localparam int S_HALT      = 6;

    localparam logic [6:0] ST_IDLE      = 7'b000_0001;
    localparam logic [6:0] ST_LAUNCH    = 7'b000_0010;
    localparam logic [6:0] ST_WAIT_BUSY = 7'b000_0100;
    localparam logic [6:0] ST_RUN       = 7'b000_1000;
    localparam logic [6:0] ST_DONE      = 7'b001_0000;
    localparam logic [6:0] ST_DRAIN     = 7'b010_0000;
    localparam logic [6:0] ST_HALT      = 7'b100_0000;

    typedef struct packed {
        logic [DESC_AW-1:0] in_base;
        logic [DESC_AW-1:0] out_base;
        logic [DESC_AW-1:0] wgt_addr;
    } desc_t;

endpackage

// File: rtl/conv_desc_fifo.sv
// Descriptor FIFO: DEPTH entries of W bits, wrap-bit pointers, synchronous flush
// that also discards a push issued in the same cycle.
module conv_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q;
    logic [PW:0]  rd_q;
    logic         do_push_s;
    logic         do_pop_s;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_push_s = push_i & ~full_o & ~flush_i;
    assign do_pop_s  = pop_i & ~empty_o & ~flush_i;
    assign rdata_o   = mem_q[rd_q[PW-1:0]];

    // Pointer update; flush empties the queue outright.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_q <= {(PW+1){1'b0}};
            rd_q <= {(PW+1){1'b0}};
        end else if (flush_i) begin
            wr_q <= {(PW+1){1'b0}};
            rd_q <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) wr_q <= wr_q + {{PW{1'b0}}, 1'b1};
            if (do_pop_s)  rd_q <= rd_q + {{PW{1'b0}}, 1'b1};
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/conv_job_scheduler.sv
// Launches queued conv jobs one at a time over the engine run/busy handshake,
// holding descriptor fields per job, counting completions and trapping hangs.
module conv_job_scheduler
    import conv_job_scheduler_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int AW       = DESC_AW,
    parameter int START_TO = 8,
    parameter int RUN_TO   = 4096,
    parameter int CNTW     = 8
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [AW-1:0]   job_in_base,
    input  logic [AW-1:0]   job_out_base,
    input  logic [AW-1:0]   job_wgt_addr,
    input  logic            abort,
    input  logic            err_clear,
    output logic            eng_run,
    input  logic            eng_busy,
    output logic [AW-1:0]   eng_in_base,
    output logic [AW-1:0]   eng_out_base,
    output logic [AW-1:0]   eng_wgt_addr,
    output logic            sched_busy,
    output logic            job_done,
    output logic [CNTW-1:0] jobs_done,
    output logic            err_timeout
);
    localparam int WDW = $clog2(RUN_TO);
    localparam logic [WDW-1:0] START_LIM = WDW'(START_TO - 1);
    localparam logic [WDW-1:0] RUN_LIM   = WDW'(RUN_TO - 1);
    localparam logic [WDW-1:0] WD_MAX    = {WDW{1'b1}};

    logic [6:0]      state_q, state_d;
    logic [WDW-1:0]  wdog_q, wdog_d, wdog_inc_s;
    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   in_q, out_q, wgt_q;
    logic            ready_en_q;
    logic            pop_s, fifo_full_s, fifo_empty_s;
    logic [3*AW-1:0] fifo_rdata_s;

    conv_desc_fifo #(.DEPTH(DEPTH), .W(3 * AW)) u_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .push_i  (job_valid),
        .pop_i   (pop_s),
        .flush_i (abort),
        .wdata_i ({job_in_base, job_out_base, job_wgt_addr}),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // The ready mask keeps job_ready low while reset is asserted.
    assign job_ready    = ready_en_q & ~fifo_full_s;
    assign eng_run      = state_q[S_LAUNCH];
    assign job_done     = state_q[S_DONE];
    assign sched_busy   = ~state_q[S_IDLE] | ~fifo_empty_s;
    assign err_timeout  = err_q;
    assign jobs_done    = cnt_q;
    assign eng_in_base  = in_q;
    assign eng_out_base = out_q;
    assign eng_wgt_addr = wgt_q;
    assign wdog_inc_s   = (wdog_q == WD_MAX) ? wdog_q : wdog_q + {{(WDW-1){1'b0}}, 1'b1};

    // Next-state logic for the job FSM, watchdog, error flag and counter.
    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && !abort) begin
                    pop_s   = 1'b1;
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                wdog_d  = {WDW{1'b0}};
                state_d = abort ? ST_DRAIN : ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (eng_busy) begin
                    state_d = ST_RUN;
                    wdog_d  = {WDW{1'b0}};
                end else if (wdog_q == START_LIM) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end else begin
                    wdog_d  = wdog_inc_s;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (!eng_busy) begin
                    state_d = ST_DONE;
                    cnt_d   = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                end else if (wdog_q == RUN_LIM) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end else begin
                    wdog_d  = wdog_inc_s;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_DRAIN: state_d = eng_busy ? ST_DRAIN : ST_IDLE;
            ST_HALT: begin
                if (err_clear) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= ST_IDLE;
            wdog_q     <= {WDW{1'b0}};
            err_q      <= 1'b0;
            cnt_q      <= {CNTW{1'b0}};
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
        end
    end

    // Descriptor hold registers, loaded only when a job is popped.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            in_q  <= {AW{1'b0}};
            out_q <= {AW{1'b0}};
            wgt_q <= {AW{1'b0}};
        end else if (pop_s) begin
            in_q  <= fifo_rdata_s[3*AW-1 -: AW];
            out_q <= fifo_rdata_s[2*AW-1 -: AW];
            wgt_q <= fifo_rdata_s[AW-1:0];
        end
    end

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Scoreboard bench for conv_job_scheduler with a behavioural conv-engine model.
module tb_conv_job_scheduler;
    import conv_job_scheduler_pkg::*;

    localparam int DEPTH    = 4;
    localparam int AW       = 12;
    localparam int START_TO = 8;
    localparam int RUN_TO   = 4096;
    localparam int CNTW     = 8;

    logic clk = 1'b0;
    logic reset_b, job_valid, job_ready, abort, err_clear, eng_run, eng_busy;
    logic [AW-1:0] job_in_base, job_out_base, job_wgt_addr;
    logic [AW-1:0] eng_in_base, eng_out_base, eng_wgt_addr;
    logic sched_busy, job_done, err_timeout;
    logic [CNTW-1:0] jobs_done;

    conv_job_scheduler #(.DEPTH(DEPTH), .AW(AW), .START_TO(START_TO),
                         .RUN_TO(RUN_TO), .CNTW(CNTW)) dut (
        .clk(clk), .reset_b(reset_b), .job_valid(job_valid), .job_ready(job_ready),
        .job_in_base(job_in_base), .job_out_base(job_out_base), .job_wgt_addr(job_wgt_addr),
        .abort(abort), .err_clear(err_clear), .eng_run(eng_run), .eng_busy(eng_busy),
        .eng_in_base(eng_in_base), .eng_out_base(eng_out_base), .eng_wgt_addr(eng_wgt_addr),
        .sched_busy(sched_busy), .job_done(job_done), .jobs_done(jobs_done),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0;
    desc_t exp_q[$];
    desc_t last_desc;
    int run_count = 0, done_pulses = 0, last_run_cyc = 0, rst_age = 0;

    // Engine model config: 0 normal, 2 never raises busy, 3 busy stuck high.
    int eng_mode = 0, eng_dly_max = 0, eng_len_min = 1, eng_len_max = 1;
    int e_phase, e_cnt, e_len, completed_jobs;
    logic e_abort;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Conv engine: registered busy, start delay, run length, completion count.
    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            eng_busy <= 1'b0; e_phase <= 0; e_cnt <= 0; e_len <= 0;
            e_abort <= 1'b0; completed_jobs <= 0;
        end else begin
            if (abort && e_phase != 0) e_abort <= 1'b1;
            case (e_phase)
                0: if (eng_run && eng_mode != 2) begin
                    e_abort <= 1'b0;
                    e_cnt   <= $urandom_range(eng_dly_max, 0);
                    e_len   <= $urandom_range(eng_len_max, eng_len_min);
                    e_phase <= 1;
                end
                1: if (e_cnt == 0) begin
                    eng_busy <= 1'b1; e_cnt <= e_len; e_phase <= 2;
                end else begin
                    e_cnt <= e_cnt - 1;
                end
                default: if (eng_mode != 3) begin
                    if (e_cnt <= 1) begin
                        eng_busy <= 1'b0; e_phase <= 0;
                        if (!e_abort && !abort) completed_jobs <= completed_jobs + 1;
                    end else begin
                        e_cnt <= e_cnt - 1;
                    end
                end
            endcase
        end
    end

    // Monitor: launches against the queued descriptors, done count, ready vs occupancy.
    initial begin
        desc_t e;
        last_desc = '0;
        forever begin
            @(negedge clk);
            if (!reset_b) begin
                last_desc = '0;
                rst_age = 0;
            end else begin
                if (rst_age < 3) rst_age++;
                if (eng_run) begin
                    run_count++;
                    last_run_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_launch", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        last_desc = e;
                    end
                end
                check("eng_fields", {eng_in_base, eng_out_base, eng_wgt_addr}, last_desc);
                if (job_done) begin
                    done_pulses++;
                    check("jobs_done_count", jobs_done, completed_jobs[CNTW-1:0]);
                end
                if (rst_age >= 2) check("job_ready", job_ready, exp_q.size() < DEPTH);
            end
        end
    end

    task automatic push_job(input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                            input logic [AW-1:0] wa, output int pc);
        int w = 0;
        @(negedge clk);
        job_valid = 1'b1; job_in_base = ib; job_out_base = ob; job_wgt_addr = wa;
        while (!job_ready && w < 10000) begin
            @(negedge clk);
            w++;
        end
        if (!job_ready) check("push_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        if (job_ready) exp_q.push_back(desc_t'{ib, ob, wa});
        #1;
        pc = cyc;
        job_valid = 1'b0;
    endtask

    task automatic push_rand(output int pc);
        push_job(AW'($urandom), AW'($urandom), AW'($urandom), pc);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && !sched_busy && !eng_busy) && n < bound);
        check({name, "_idle"}, exp_q.size() == 0 && !sched_busy && !eng_busy, 64'd1);
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int pc, d0, r0, n, ec;
        reset_b = 1'b0; job_valid = 1'b0; abort = 1'b0; err_clear = 1'b0;
        job_in_base = '0; job_out_base = '0; job_wgt_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {job_ready, eng_run, eng_in_base, eng_out_base, eng_wgt_addr,
                                sched_busy, job_done, jobs_done, err_timeout}, 64'd0);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);

        // Single job: launch two cycles after the push cycle, one completion.
        eng_len_min = 30; eng_len_max = 30;
        d0 = done_pulses;
        push_job(12'h000, 12'h040, 12'h001, pc);
        wait_idle("single", 300);
        check("single_launch_cycle", last_run_cyc, pc + 1);
        check("single_done_pulses", done_pulses - d0, 64'd1);
        check("single_jobs_done", jobs_done, 64'd1);

        // Five jobs into a four-deep queue behind a long-running job.
        eng_len_min = 40; eng_len_max = 40;
        d0 = done_pulses;
        for (int i = 0; i < 5; i++) push_rand(pc);
        @(negedge clk);
        check("five_ready_low", job_ready, 64'd0);
        wait_idle("five", 600);
        check("five_done_pulses", done_pulses - d0, 64'd5);
        check("five_jobs_done", jobs_done, 64'd6);

        // Engine never starts: start watchdog halts, queue is retained.
        eng_mode = 2;
        r0 = run_count; d0 = done_pulses;
        for (int i = 0; i < 3; i++) push_rand(pc);
        n = 0;
        while (!err_timeout && n < 100) begin @(negedge clk); n++; end
        ec = cyc;
        check("start_to_err", err_timeout, 64'd1);
        check("start_to_latency", ec - last_run_cyc, START_TO + 1);
        repeat (10) @(negedge clk);
        check("halt_no_launch", run_count - r0, 64'd1);
        check("halt_sched_busy", sched_busy, 64'd1);
        check("halt_queue_kept", exp_q.size(), 64'd2);
        eng_mode = 0; eng_len_min = 5; eng_len_max = 5;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("err_cleared", err_timeout, 64'd0);
        wait_idle("resume", 300);
        check("resume_done_pulses", done_pulses - d0, 64'd2);
        check("resume_jobs_done", jobs_done, 64'd8);

        // Abort during RUN with two queued; a push in the abort cycle is dropped.
        eng_len_min = 40; eng_len_max = 40;
        for (int i = 0; i < 3; i++) push_rand(pc);
        n = 0;
        while (!eng_busy && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        r0 = run_count; d0 = done_pulses;
        abort = 1'b1; job_valid = 1'b1; job_in_base = 12'hABC;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        abort = 1'b0; job_valid = 1'b0;
        check("abort_ready", job_ready, 64'd1);
        check("abort_drain_busy", sched_busy, 64'd1);
        n = 0;
        while (eng_busy && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("abort_idle", sched_busy, 64'd0);
        check("abort_jobs_done", jobs_done, 64'd8);
        check("abort_no_done", done_pulses - d0, 64'd0);
        check("abort_no_launch", run_count - r0, 64'd0);

        // Busy stuck high: run watchdog.
        eng_mode = 3;
        push_rand(pc);
        n = 0;
        while (!err_timeout && n < RUN_TO + 100) begin @(negedge clk); n++; end
        check("run_to_err", err_timeout, 64'd1);
        check("run_to_latency_ok", (cyc - last_run_cyc >= RUN_TO) &&
                                   (cyc - last_run_cyc <= RUN_TO + START_TO + 2), 64'd1);
        do_reset();

        // Asynchronous reset in the middle of a running job.
        eng_mode = 0; eng_len_min = 100; eng_len_max = 100;
        push_rand(pc);
        n = 0;
        while (!eng_busy && n < 50) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        #2 reset_b = 1'b0;
        exp_q.delete();
        #1;
        check("midrun_reset_outputs", {job_ready, eng_run, eng_in_base, eng_out_base, eng_wgt_addr,
                                       sched_busy, job_done, jobs_done, err_timeout}, 64'd0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);

        // Counter wrap at 2^CNTW.
        eng_len_min = 1; eng_len_max = 1;
        for (int i = 0; i < 255; i++) push_rand(pc);
        wait_idle("wrap_fill", 4000);
        check("wrap_255", jobs_done, 64'd255);
        d0 = done_pulses;
        push_rand(pc);
        wait_idle("wrap", 100);
        check("wrap_zero", jobs_done, 64'd0);
        check("wrap_done_pulse", done_pulses - d0, 64'd1);

        // Randomised traffic with variable start delays and run lengths.
        eng_dly_max = 3; eng_len_min = 1; eng_len_max = 15;
        d0 = done_pulses;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(5, 0)) @(negedge clk);
            push_rand(pc);
        end
        wait_idle("random", 2000);
        check("random_done_pulses", done_pulses - d0, 64'd30);
        check("random_jobs_done", jobs_done, 64'd30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
